// File: rtl/pe_stream_router.sv
// Scatter/gather front end for the linear PE array.
// Scatters one word stream over PE lanes; serialises PE outputs.
module pe_stream_router #(
    parameter int PE_NUM   = 8,
    parameter int DATA_W   = 32,
    parameter int LOAD_NUM = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_bcast,
    input  logic                     i_din_v,
    input  logic [DATA_W-1:0]        i_din,
    output logic [PE_NUM-1:0]        o_pe_in_v,
    output logic [PE_NUM*DATA_W-1:0] o_pe_in,
    output logic                     o_scatter_done,
    input  logic                     i_load,
    input  logic [PE_NUM*DATA_W-1:0] i_gather_in,
    output logic                     o_dout_v,
    output logic [DATA_W-1:0]        o_dout,
    output logic                     o_dout_last,
    input  logic                     i_dout_ready,
    output logic                     o_busy,
    output logic                     o_load_drop
);

    localparam int LW = $clog2(PE_NUM);
    localparam int BW = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(PE_NUM - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(LOAD_NUM - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // scatter state
    logic [BW-1:0]            r_beat;
    logic [LW-1:0]            r_lane;
    logic                     r_mode;
    logic [PE_NUM-1:0]        r_pe_in_v;
    logic [PE_NUM*DATA_W-1:0] r_pe_in;
    logic                     r_scatter_done;

    logic                     w_first;
    logic                     w_mode;
    logic                     w_beat_last;
    logic                     w_lane_last;
    logic [PE_NUM-1:0]        w_pe_v;
    logic [PE_NUM*DATA_W-1:0] w_pe_d;

    // gather state
    state_t                   r_state;
    logic [LW-1:0]            r_idx;
    logic [DATA_W-1:0]        r_sh [PE_NUM];
    logic                     r_dout_v;
    logic [DATA_W-1:0]        r_dout;
    logic                     r_dout_last;
    logic                     r_load_drop;

    logic                     w_hs;
    logic                     w_idx_last;
    logic [LW-1:0]            w_idx_nxt;
    logic                     w_cap;

    // Round position, effective mode and next lane valids/data
    always_comb begin
        w_pe_v      = '0;
        w_pe_d      = '0;
        w_first     = (r_beat == '0) && (r_lane == '0);
        w_mode      = w_first ? i_bcast : r_mode;
        w_beat_last = (r_beat == BEAT_LAST);
        w_lane_last = (r_lane == LANE_LAST);
        for (int j = 0; j < PE_NUM; j++) begin
            w_pe_v[j] = i_din_v & (w_mode | (r_lane == LW'(j)));
            w_pe_d[j*DATA_W +: DATA_W] = w_pe_v[j] ? i_din : '0;
        end
    end

    // Scatter counters, mode latch and registered lane outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat         <= '0;
            r_lane         <= '0;
            r_mode         <= 1'b0;
            r_pe_in_v      <= '0;
            r_pe_in        <= '0;
            r_scatter_done <= 1'b0;
        end else begin
            r_pe_in_v      <= w_pe_v;
            r_pe_in        <= w_pe_d;
            r_scatter_done <= 1'b0;
            if (i_din_v) begin
                if (w_first) begin
                    r_mode <= i_bcast;
                end
                if (w_beat_last) begin
                    r_beat <= '0;
                    if (w_mode || w_lane_last) begin
                        r_lane         <= '0;
                        r_scatter_done <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    // Handshake and capture conditions for the gather side
    always_comb begin
        w_hs       = r_dout_v & i_dout_ready;
        w_idx_last = (r_idx == LANE_LAST);
        w_idx_nxt  = r_idx + 1'b1;
        w_cap      = i_load &
                     ((r_state == S_IDLE) || (w_hs && w_idx_last));
    end

    // Parallel capture of PE outputs (data path, no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_cap) begin
            for (int j = 0; j < PE_NUM; j++) begin
                r_sh[j] <= i_gather_in[j*DATA_W +: DATA_W];
            end
        end
    end

    // Gather FSM with registered serial outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_dout_v    <= 1'b0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
            r_load_drop <= 1'b0;
        end else begin
            r_load_drop <= 1'b0;
            if (w_cap) begin
                r_state     <= S_SHIFT;
                r_idx       <= '0;
                r_dout_v    <= 1'b1;
                r_dout      <= i_gather_in[DATA_W-1:0];
                r_dout_last <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dout_v    <= 1'b0;
                        r_dout      <= '0;
                        r_dout_last <= 1'b0;
                    end
                    S_SHIFT: begin
                        r_load_drop <= i_load;
                        if (w_hs) begin
                            if (w_idx_last) begin
                                r_state     <= S_IDLE;
                                r_idx       <= '0;
                                r_dout_v    <= 1'b0;
                                r_dout      <= '0;
                                r_dout_last <= 1'b0;
                            end else begin
                                r_idx       <= w_idx_nxt;
                                r_dout      <= r_sh[w_idx_nxt];
                                r_dout_last <= (w_idx_nxt == LANE_LAST);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_pe_in_v      = r_pe_in_v;
    assign o_pe_in        = r_pe_in;
    assign o_scatter_done = r_scatter_done;
    assign o_dout_v       = r_dout_v;
    assign o_dout         = r_dout;
    assign o_dout_last    = r_dout_last;
    assign o_busy         = (r_state == S_SHIFT);
    assign o_load_drop    = r_load_drop;

endmodule

// File: tb/tb_pe_stream_router.sv
// Bench for pe_stream_router: hand-written vector table plus
// randomized traffic against a queue-based reference model.
module tb_pe_stream_router;

    localparam int P = 4;
    localparam int L = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           bc = 1'b0;
    logic           dv = 1'b0;
    logic [W-1:0]   din = '0;
    logic           ld = 1'b0;
    logic           rdy = 1'b1;
    logic [P*W-1:0] gin = '0;

    logic [P-1:0]   pe_v;
    logic [P*W-1:0] pe_d;
    logic           sdone;
    logic           dout_v;
    logic [W-1:0]   dout;
    logic           dlast;
    logic           busy;
    logic           drop;

    pe_stream_router #(.PE_NUM(P), .DATA_W(W), .LOAD_NUM(L)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bcast        (bc),
        .i_din_v        (dv),
        .i_din          (din),
        .o_pe_in_v      (pe_v),
        .o_pe_in        (pe_d),
        .o_scatter_done (sdone),
        .i_load         (ld),
        .i_gather_in    (gin),
        .o_dout_v       (dout_v),
        .o_dout         (dout),
        .o_dout_last    (dlast),
        .i_dout_ready   (rdy),
        .o_busy         (busy),
        .o_load_drop    (drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int             m_pos = 0;
    bit             m_bc = 1'b0;
    logic [W-1:0]   m_q[$];
    logic [P-1:0]   e_v;
    logic [P*W-1:0] e_pe;
    logic           e_done, e_dv, e_last, e_drop;
    logic [W-1:0]   e_dout;

    typedef struct {
        bit           rst, bc, dv;
        logic [W-1:0] din;
        bit           ld, rdy;
        logic [P-1:0] ev;
        bit           edone, edv;
        logic [W-1:0] edout;
        bit           elast, edrop;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic refill();
        m_q.delete();
        for (int j = 0; j < P; j++) m_q.push_back(gin[j*W +: W]);
    endtask

    // Model: scatter by position within the round, gather as a word queue
    task automatic model_step();
        bit busy0;
        e_done = 1'b0;
        e_drop = 1'b0;
        e_v    = '0;
        e_pe   = '0;
        if (rst) begin
            m_pos = 0;
            m_bc  = 1'b0;
            m_q.delete();
        end else begin
            if (dv) begin
                if (m_pos == 0) m_bc = bc;
                for (int j = 0; j < P; j++) begin
                    if (m_bc || (m_pos / L) == j) begin
                        e_v[j] = 1'b1;
                        e_pe[j*W +: W] = din;
                    end
                end
                m_pos++;
                if (m_pos == (m_bc ? L : P * L)) begin
                    m_pos  = 0;
                    e_done = 1'b1;
                end
            end
            busy0 = (m_q.size() > 0);
            if (!busy0) begin
                if (ld) refill();
            end else if (rdy && m_q.size() == 1) begin
                void'(m_q.pop_front());
                if (ld) refill();
            end else begin
                e_drop = ld;
                if (rdy) void'(m_q.pop_front());
            end
        end
        e_dv   = (m_q.size() > 0);
        e_dout = e_dv ? m_q[0] : '0;
        e_last = (m_q.size() == 1);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_pe_in_v"}, 128'(pe_v), 128'(e_v));
        chk({tag, "_pe_in"}, 128'(pe_d), 128'(e_pe));
        chk({tag, "_scatter_done"}, 128'(sdone), 128'(e_done));
        chk({tag, "_dout_v"}, 128'(dout_v), 128'(e_dv));
        chk({tag, "_dout"}, 128'(dout), 128'(e_dout));
        chk({tag, "_dout_last"}, 128'(dlast), 128'(e_last));
        chk({tag, "_busy"}, 128'(busy), 128'(e_dv));
        chk({tag, "_load_drop"}, 128'(drop), 128'(e_drop));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_model(tag);
    endtask

    function automatic vec_t mk(bit r, bit b, bit v, logic [W-1:0] d,
                                bit l, bit y, logic [P-1:0] ev, bit ed,
                                bit edv, logic [W-1:0] eo, bit el,
                                bit er);
        vec_t t;
        t.rst = r;   t.bc = b;     t.dv = v;    t.din = d;
        t.ld = l;    t.rdy = y;    t.ev = ev;   t.edone = ed;
        t.edv = edv; t.edout = eo; t.elast = el; t.edrop = er;
        return t;
    endfunction

    function automatic vec_t mks(bit b, bit v, logic [W-1:0] d,
                                 logic [P-1:0] ev, bit ed);
        return mk(1'b0, b, v, d, 1'b0, 1'b1, ev, ed, 1'b0, '0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t mkg(bit l, bit y, bit edv, logic [W-1:0] eo,
                                 bit el, bit er);
        return mk(1'b0, 1'b0, 1'b0, '0, l, y, '0, 1'b0, edv, eo, el, er);
    endfunction

    initial begin
        string tg;
        gin = {32'h44, 32'h33, 32'h22, 32'h11};

        // reset state
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // plain 12-beat stream
        for (int k = 1; k <= 12; k++)
            vt.push_back(mks(0, 1, k, 4'(1 << ((k - 1) / L)), k == 12));
        vt.push_back(mks(0, 0, 0, 0, 0));
        // same stream with a 5-cycle bubble after word 4
        for (int k = 1; k <= 12; k++) begin
            vt.push_back(mks(0, 1, k, 4'(1 << ((k - 1) / L)), k == 12));
            if (k == 4)
                for (int b = 0; b < 5; b++) vt.push_back(mks(0, 0, 0, 0, 0));
        end
        // broadcast round, then bcast drops mid-round
        vt.push_back(mks(1, 1, 'hA, 4'hF, 0));
        vt.push_back(mks(0, 1, 'hB, 4'hF, 0));
        vt.push_back(mks(0, 1, 'hC, 4'hF, 1));
        vt.push_back(mks(0, 1, 'hD, 4'h1, 0));
        vt.push_back(mks(0, 0, 0, 0, 0));
        // gather with backpressure, dropped load, back-to-back frame
        vt.push_back(mkg(1, 1, 1, 'h11, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h22, 0, 0));
        vt.push_back(mkg(1, 0, 1, 'h22, 0, 1));
        vt.push_back(mkg(0, 0, 1, 'h22, 0, 0));
        vt.push_back(mkg(0, 0, 1, 'h22, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h33, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h44, 1, 0));
        vt.push_back(mkg(1, 1, 1, 'h11, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h22, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h33, 0, 0));
        vt.push_back(mkg(0, 1, 1, 'h44, 1, 0));
        vt.push_back(mkg(0, 1, 0, 0, 0, 0));
        // reset mid-operation
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 1, 'h11, 0, 0));
        vt.push_back(mk(0, 0, 1, 2, 0, 1, 1, 0, 1, 'h22, 0, 0));
        vt.push_back(mk(0, 0, 1, 3, 0, 1, 1, 0, 1, 'h33, 0, 0));
        vt.push_back(mk(0, 0, 1, 4, 0, 0, 2, 0, 1, 'h33, 0, 0));
        vt.push_back(mk(0, 0, 1, 5, 0, 0, 2, 0, 1, 'h33, 0, 0));
        vt.push_back(mk(0, 0, 1, 6, 0, 0, 2, 0, 1, 'h33, 0, 0));
        vt.push_back(mk(0, 0, 1, 7, 0, 0, 4, 0, 1, 'h33, 0, 0));
        vt.push_back(mk(1, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++)
            vt.push_back(mks(0, 1, k, 4'(1 << ((k - 1) / L)), k == 12));
        vt.push_back(mks(0, 0, 0, 0, 0));

        // apply the table
        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; bc = vt[i].bc; dv = vt[i].dv;
            din = vt[i].din; ld = vt[i].ld; rdy = vt[i].rdy;
            tg = $sformatf("v%0d", i);
            tick(tg);
            chk({tg, "_t_pe_in_v"}, 128'(pe_v), 128'(vt[i].ev));
            for (int j = 0; j < P; j++)
                chk($sformatf("%s_t_lane%0d", tg, j),
                    128'(pe_d[j*W +: W]),
                    128'(vt[i].ev[j] ? vt[i].din : '0));
            chk({tg, "_t_done"}, 128'(sdone), 128'(vt[i].edone));
            chk({tg, "_t_dout_v"}, 128'(dout_v), 128'(vt[i].edv));
            chk({tg, "_t_dout"}, 128'(dout), 128'(vt[i].edout));
            chk({tg, "_t_last"}, 128'(dlast), 128'(vt[i].elast));
            chk({tg, "_t_busy"}, 128'(busy), 128'(vt[i].edv));
            chk({tg, "_t_drop"}, 128'(drop), 128'(vt[i].edrop));
        end

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            bc  = $urandom_range(0, 1) == 1;
            dv  = ($urandom_range(0, 9) < 7);
            din = $urandom;
            ld  = ($urandom_range(0, 9) < 2);
            rdy = ($urandom_range(0, 9) < 6);
            for (int j = 0; j < P; j++) gin[j*W +: W] = $urandom;
            tick($sformatf("r%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
